// File: rtl/sort4_pkg.sv
// Shared definitions for the sort4 sequential sorter: state encoding,
// step count and the bubble-network pair schedule.
package sort4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SORT_STEPS = 6;
  localparam logic [2:0] LAST_STEP = 3'(SORT_STEPS - 1);

  // Lower index i of the pair (i, i+1) handled at each step: 0,1,2,0,1,0.
  function automatic logic [1:0] pair_idx(input logic [2:0] step);
    logic [1:0] idx;
    idx = 2'd0;
    case (step)
      3'd0:    idx = 2'd0;
      3'd1:    idx = 2'd1;
      3'd2:    idx = 2'd2;
      3'd3:    idx = 2'd0;
      3'd4:    idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/en_reg.sv
// Existing enable-register primitive: asynchronous active-high clear,
// loads d_i on the rising edge when en_i is high.
module en_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mux2.sv
// Existing 2:1 mux primitive of the lab datapath.
module mux2 #(
  parameter int N = 4
) (
  input  logic         sel_i,
  input  logic [N-1:0] d0_i,
  input  logic [N-1:0] d1_i,
  output logic [N-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/sort4_cmp_swap.sv
// Combinational compare-exchange: orders an unsigned pair and flags
// whether the pair was out of order.
module cmp_swap #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort4.sv
// Four-entry in-place bubble sorter: one compare-exchange per cycle over
// six fixed steps, using a single shared cmp_swap.
module sort4
  import sort4_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  output logic [N-1:0] s0,
  output logic [N-1:0] s1,
  output logic [N-1:0] s2,
  output logic [N-1:0] s3,
  output logic         busy,
  output logic         done,
  output state_e       dbg_state_o,
  output logic [2:0]   dbg_step_o
);

  // start is a one-cycle request honoured only in IDLE or DONE; done stays
  // high with s0..s3 valid until the next accepted start.
  state_e     state_q;
  logic [2:0] step_q;

  logic       accept;
  logic       xchg_en;
  logic [1:0] pair;
  logic [N-1:0] a_01, b_12, op_a, op_b, lo, hi;
  logic       swap;
  logic [N-1:0] s1_x, s2_x;
  logic [N-1:0] s0_d, s1_d, s2_d, s3_d;
  logic       en0, en1, en2, en3;

  assign accept  = start && (state_q != ST_SORT);
  assign pair    = pair_idx(step_q);
  assign xchg_en = (state_q == ST_SORT) && swap;

  // Operand select: a = s[pair], b = s[pair+1].
  mux2 #(.N(N)) u_a_lo (.sel_i(pair[0]), .d0_i(s0),   .d1_i(s1), .y_o(a_01));
  mux2 #(.N(N)) u_a_hi (.sel_i(pair[1]), .d0_i(a_01), .d1_i(s2), .y_o(op_a));
  mux2 #(.N(N)) u_b_lo (.sel_i(pair[0]), .d0_i(s1),   .d1_i(s2), .y_o(b_12));
  mux2 #(.N(N)) u_b_hi (.sel_i(pair[1]), .d0_i(b_12), .d1_i(s3), .y_o(op_b));

  cmp_swap #(.N(N)) u_cmp (.a(op_a), .b(op_b), .lo(lo), .hi(hi), .swap(swap));

  // s1 takes hi when it is the upper slot of pair 0, lo as lower slot of pair 1;
  // s2 likewise for pairs 1 and 2.
  mux2 #(.N(N)) u_s1_x (.sel_i(pair[0]), .d0_i(hi), .d1_i(lo), .y_o(s1_x));
  mux2 #(.N(N)) u_s2_x (.sel_i(pair[1]), .d0_i(hi), .d1_i(lo), .y_o(s2_x));

  mux2 #(.N(N)) u_s0_d (.sel_i(accept), .d0_i(lo),   .d1_i(x0), .y_o(s0_d));
  mux2 #(.N(N)) u_s1_d (.sel_i(accept), .d0_i(s1_x), .d1_i(x1), .y_o(s1_d));
  mux2 #(.N(N)) u_s2_d (.sel_i(accept), .d0_i(s2_x), .d1_i(x2), .y_o(s2_d));
  mux2 #(.N(N)) u_s3_d (.sel_i(accept), .d0_i(hi),   .d1_i(x3), .y_o(s3_d));

  // Only the active pair is written, and only when it actually swaps.
  assign en0 = accept || (xchg_en && (pair == 2'd0));
  assign en1 = accept || (xchg_en && (pair == 2'd0 || pair == 2'd1));
  assign en2 = accept || (xchg_en && (pair == 2'd1 || pair == 2'd2));
  assign en3 = accept || (xchg_en && (pair == 2'd2));

  en_reg #(.N(N)) u_r0 (.clk(clk), .rst(rst), .en_i(en0), .d_i(s0_d), .q_o(s0));
  en_reg #(.N(N)) u_r1 (.clk(clk), .rst(rst), .en_i(en1), .d_i(s1_d), .q_o(s1));
  en_reg #(.N(N)) u_r2 (.clk(clk), .rst(rst), .en_i(en2), .d_i(s2_d), .q_o(s2));
  en_reg #(.N(N)) u_r3 (.clk(clk), .rst(rst), .en_i(en3), .d_i(s3_d), .q_o(s3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_SORT;
            step_q  <= 3'd0;
          end
        end
        ST_SORT: begin
          if (step_q == LAST_STEP) begin
            state_q <= ST_DONE;
            step_q  <= 3'd0;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 3'd0;
        end
      endcase
    end
  end

  assign busy        = (state_q == ST_SORT);
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;
  assign dbg_step_o  = step_q;

endmodule

// File: tb/tb_sort4.sv
// Self-checking bench for sort4: reset, table vectors, corner sequences
// and random vectors against a selection-sort reference model.
module tb_sort4;
  import sort4_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] x0, x1, x2, x3;
  logic [N-1:0] s0, s1, s2, s3;
  logic         busy, done;
  state_e       dbg_state;
  logic [2:0]   dbg_step;
  logic [4*N-1:0] s_all;

  sort4 #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .busy(busy), .done(done),
    .dbg_state_o(dbg_state), .dbg_step_o(dbg_step)
  );

  assign s_all = {s3, s2, s1, s0};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4*N-1:0] exp_q[$];

  typedef struct {
    logic [4*N-1:0] xv;
    logic [4*N-1:0] ev;
    bit             all_equal;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [4*N-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {N'(a3), N'(a2), N'(a1), N'(a0)};
  endfunction

  // Reference: repeatedly extract the minimum of the remaining values.
  function automatic logic [4*N-1:0] ref_sort(input logic [4*N-1:0] v);
    int q[$];
    logic [4*N-1:0] res;
    int mi;
    res = '0;
    for (int i = 0; i < 4; i++) q.push_back(int'(v[i*N +: N]));
    for (int k = 0; k < 4; k++) begin
      mi = 0;
      for (int j = 1; j < q.size(); j++) if (q[j] < q[mi]) mi = j;
      res[k*N +: N] = N'(q[mi]);
      q.delete(mi);
    end
    return res;
  endfunction

  // driver: one full sort from accept edge to done
  task automatic run_sort(input logic [4*N-1:0] xv, input logic [4*N-1:0] ev, input bit hold_equal);
    int lat;
    int busy_cnt;
    @(negedge clk);
    {x3, x2, x1, x0} = xv;
    start = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    start = 1'b0;
    {x3, x2, x1, x0} = 16'($urandom);
    check("accept_busy", busy, 1);
    check("accept_done_low", done, 0);
    check("accept_load", s_all, xv);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (hold_equal) check("equal_no_write", s_all, xv);
    end
    check("latency", lat, 6);
    check("busy_cycles", busy_cnt, 6);
    check("result", s_all, exp_q.pop_front());
  endtask

  task automatic hold_check(input int cycles);
    logic [4*N-1:0] v;
    v = s_all;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("hold_done", done, 1);
      check("hold_value", s_all, v);
    end
  endtask

  vec_t tbl[5];

  initial begin
    logic [4*N-1:0] xv;

    tbl[0] = '{pack4(3, 1, 2, 0),     pack4(0, 1, 2, 3),     1'b0};
    tbl[1] = '{pack4(1, 2, 3, 4),     pack4(1, 2, 3, 4),     1'b0};
    tbl[2] = '{pack4(15, 14, 13, 12), pack4(12, 13, 14, 15), 1'b0};
    tbl[3] = '{pack4(5, 5, 0, 5),     pack4(0, 5, 5, 5),     1'b0};
    tbl[4] = '{pack4(7, 7, 7, 7),     pack4(7, 7, 7, 7),     1'b1};

    rst = 1'b0;
    start = 1'b0;
    {x3, x2, x1, x0} = '0;

    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_s", s_all, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("idle_s", s_all, 0);
      check("idle_flags", {busy, done}, 0);
    end

    // table vectors
    for (int i = 0; i < 5; i++) begin
      run_sort(tbl[i].xv, tbl[i].ev, tbl[i].all_equal);
      if (i == 0) hold_check(10);
    end

    // start held high through SORT with x changing every cycle
    @(negedge clk);
    {x3, x2, x1, x0} = pack4(4, 3, 2, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("held_accept_busy", busy, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      {x3, x2, x1, x0} = 16'($urandom);
      @(posedge clk);
      #1;
    end
    check("held_done", done, 1);
    check("held_result", s_all, pack4(1, 2, 3, 4));
    @(negedge clk);
    start = 1'b0;

    // restart from DONE
    check("pre_restart_done", done, 1);
    run_sort(pack4(9, 8, 7, 6), pack4(6, 7, 8, 9), 1'b0);

    // asynchronous reset between the step-2 and step-3 edges
    @(negedge clk);
    {x3, x2, x1, x0} = pack4(6, 5, 4, 3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_s", s_all, 0);
    check("midrst_flags", {busy, done}, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_step", dbg_step, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sort(pack4(2, 0, 3, 1), pack4(0, 1, 2, 3), 1'b0);

    // random vectors against the reference model
    for (int r = 0; r < 30; r++) begin
      xv = 16'($urandom);
      run_sort(xv, ref_sort(xv), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
